// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and constants for the divider-sharing controller.
//   state_e       - controller FSM states
//   DATA_W        - operand/result width
//   DIV_ZERO_QUOT - quotient reported for a bypassed divide-by-zero
package div_share_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if: request, divider and response channels of div_share_ctrl.
//   master : controller side (drives req_ready, div_*, resp_*, busy)
//   slave  : environment side (requesters, divider core, response consumer)
interface div_share_ctrl_if import div_share_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dividend;
    logic [NUM_REQ*DATA_W-1:0] req_divisor;
    logic                      div_start;
    logic [DATA_W-1:0]         div_dividend;
    logic [DATA_W-1:0]         div_divisor;
    logic                      div_done;
    logic [DATA_W-1:0]         div_quotient;
    logic [DATA_W-1:0]         div_remainder;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_quotient;
    logic [DATA_W-1:0]         resp_remainder;
    logic                      resp_div_zero;
    logic                      busy;

    modport master (
        input  req_valid, req_dividend, req_divisor, div_done, div_quotient, div_remainder, resp_ready,
        output req_ready, div_start, div_dividend, div_divisor, resp_valid, resp_id,
               resp_quotient, resp_remainder, resp_div_zero, busy
    );

    modport slave (
        output req_valid, req_dividend, req_divisor, div_done, div_quotient, div_remainder, resp_ready,
        input  req_ready, div_start, div_dividend, div_divisor, resp_valid, resp_id,
               resp_quotient, resp_remainder, resp_div_zero, busy
    );
endinterface

// File: rtl/div_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   - request vector
//   ptr_i   - highest-priority index this cycle
//   gnt_o   - one-hot grant (zero when no request)
//   idx_o   - encoded index of the grant
//   valid_o - any request granted
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);
    logic [ID_W-1:0] j;

    // Walk from the pointer, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = ptr_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = j;
                valid_o  = 1'b1;
            end
            j = (j == ID_W'(NUM_REQ - 1)) ? '0 : j + 1'b1;
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one sequential divider among NUM_REQ requesters.
//   clk - clock, rising edge
//   rst - synchronous active-low reset
//   bus - div_share_ctrl_if.master: per-requester req_* handshake, div_* divider
//         port, resp_* tagged response channel, busy
// Optional feature: define DIV_SHARE_ZERO_BYPASS_EN to answer zero divisors
// directly (quotient all ones, remainder = dividend) without starting the divider.
module div_share_ctrl import div_share_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic              clk,
    input logic              rst,
    div_share_ctrl_if.master bus
);
    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d, id_q, id_d, win_idx;
    logic [NUM_REQ-1:0] win_gnt;
    logic               win_valid;
    logic [DATA_W-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, quot_q, quot_d, rem_q, rem_d;
    logic [DATA_W-1:0]  in_dvd [NUM_REQ];
    logic [DATA_W-1:0]  in_dvs [NUM_REQ];
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    logic               dz_q, dz_d;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign in_dvd[g] = bus.req_dividend[DATA_W*g +: DATA_W];
        assign in_dvs[g] = bus.req_divisor[DATA_W*g +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: if (win_valid) begin
                id_d    = win_idx;
                dvd_d   = in_dvd[win_idx];
                dvs_d   = in_dvs[win_idx];
                state_d = ISSUE;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
                dz_d    = in_dvs[win_idx] == '0;
                if (dz_d) begin
                    quot_d  = DIV_ZERO_QUOT;
                    rem_d   = in_dvd[win_idx];
                    state_d = RESP;
                end
`endif
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.div_done) begin
                quot_d  = bus.div_quotient;
                rem_d   = bus.div_remainder;
                state_d = RESP;
            end
            RESP: if (bus.resp_ready) begin
                // Next search starts just past the requester just served.
                rr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            dz_q    <= dz_d;
`endif
        end
    end

    // Grant is combinational in IDLE; suppressed while reset is asserted so
    // nothing is handshaken that the reset would then discard.
    assign bus.req_ready      = (rst && state_q == IDLE) ? win_gnt : '0;
    assign bus.div_start      = state_q == ISSUE;
    assign bus.div_dividend   = dvd_q;
    assign bus.div_divisor    = dvs_q;
    assign bus.resp_valid     = state_q == RESP;
    assign bus.resp_id        = id_q;
    assign bus.resp_quotient  = quot_q;
    assign bus.resp_remainder = rem_q;
    assign bus.busy           = state_q != IDLE;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
    assign bus.resp_div_zero  = dz_q;
`else
    assign bus.resp_div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed, table-driven bench for div_share_ctrl.
module tb_div_share_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    typedef struct {
        logic [3:0]  mask;
        int          d;
        logic [1:0]  id;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] dvd_tab [4];
    logic [31:0] dvs_tab [4];

    div_share_ctrl_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    div_share_ctrl #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_div_start"}, 32'(bus.div_start), 32'd0);
        chk({tag, "_div_dividend"}, bus.div_dividend, 32'd0);
        chk({tag, "_div_divisor"}, bus.div_divisor, 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        chk({tag, "_resp_quotient"}, bus.resp_quotient, 32'd0);
        chk({tag, "_resp_remainder"}, bus.resp_remainder, 32'd0);
        chk({tag, "_resp_div_zero"}, 32'(bus.resp_div_zero), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic load_ops();
        for (int i = 0; i < 4; i++) begin
            bus.req_dividend[32*i +: 32] = dvd_tab[i];
            bus.req_divisor[32*i +: 32]  = dvs_tab[i];
        end
    endtask

    // One full operation: accept in cycle 0, start in cycle 1, done seen in
    // cycle 1+d, response from cycle 2+d, resp_ready low for 'hold' cycles.
    // 'noise' pulses div_done during RESP to prove it is ignored there.
    task automatic run_op(input logic [3:0] mask, input int d, input logic [1:0] eid,
                          input logic [31:0] eq, input logic [31:0] er, input int hold, input bit noise);
        @(negedge clk);
        bus.req_valid  = mask;
        bus.resp_ready = 1'b0;
        #1;
        chk("accept_busy", 32'(bus.busy), 32'd0);
        chk("accept_req_ready", 32'(bus.req_ready), 32'(4'b0001 << eid));
        @(negedge clk);
        #1;
        chk("issue_div_start", 32'(bus.div_start), 32'd1);
        chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
        chk("issue_div_dividend", bus.div_dividend, dvd_tab[eid]);
        chk("issue_div_divisor", bus.div_divisor, dvs_tab[eid]);
        for (int c = 2; c <= 1 + d; c++) begin
            @(negedge clk);
            if (c == 1 + d) begin
                bus.div_done      = 1'b1;
                bus.div_quotient  = (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : 32'hFFFF_FFFF;
                bus.div_remainder = (bus.div_divisor != 0) ? bus.div_dividend % bus.div_divisor : bus.div_dividend;
            end
            #1;
            chk("wait_div_start", 32'(bus.div_start), 32'd0);
            chk("wait_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("wait_req_ready", 32'(bus.req_ready), 32'd0);
            chk("wait_div_dividend", bus.div_dividend, dvd_tab[eid]);
        end
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            bus.div_done      = noise;
            bus.div_quotient  = 32'hDEAD_BEEF;
            bus.div_remainder = 32'hBAD0_0BAD;
            bus.resp_ready    = (k == hold);
            #1;
            chk("resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("resp_id", 32'(bus.resp_id), 32'(eid));
            chk("resp_quotient", bus.resp_quotient, eq);
            chk("resp_remainder", bus.resp_remainder, er);
            chk("resp_div_zero", 32'(bus.resp_div_zero), 32'd0);
            chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        bus.div_done   = 1'b0;
        #1;
        chk("after_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("after_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req_valid     = '0;
        bus.req_dividend  = '0;
        bus.req_divisor   = '0;
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        bus.resp_ready    = 1'b0;
        dvd_tab = '{32'd1000, 32'd77, 32'd100, 32'hFFFF_FFFF};
        dvs_tab = '{32'd10, 32'd5, 32'd7, 32'd16};
        load_ops();
        // Pointer sequence from reset: 0,1,0,1,2,3,1,3 -> winners below.
        vecs[0] = '{mask: 4'b1001, d: 2, id: 2'd0, q: 32'd100,        r: 32'd0};
        vecs[1] = '{mask: 4'b1001, d: 1, id: 2'd3, q: 32'h0FFF_FFFF,  r: 32'd15};
        vecs[2] = '{mask: 4'b0011, d: 4, id: 2'd0, q: 32'd100,        r: 32'd0};
        vecs[3] = '{mask: 4'b0011, d: 3, id: 2'd1, q: 32'd15,         r: 32'd2};
        vecs[4] = '{mask: 4'b1111, d: 5, id: 2'd2, q: 32'd14,         r: 32'd2};
        vecs[5] = '{mask: 4'b0111, d: 2, id: 2'd0, q: 32'd100,        r: 32'd0};
        vecs[6] = '{mask: 4'b0100, d: 3, id: 2'd2, q: 32'd14,         r: 32'd2};
        vecs[7] = '{mask: 4'b1000, d: 1, id: 2'd3, q: 32'h0FFF_FFFF,  r: 32'd15};

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;

        for (int v = 0; v < 8; v++)
            run_op(vecs[v].mask, vecs[v].d, vecs[v].id, vecs[v].q, vecs[v].r, 0, 1'b0);

        // Backpressure for 5 cycles with div_done noise during RESP.
        run_op(4'b0010, 2, 2'd1, 32'd15, 32'd2, 5, 1'b1);

        // div_done while IDLE must not start anything.
        @(negedge clk);
        bus.div_done     = 1'b1;
        bus.div_quotient = 32'h1234_5678;
        #1;
        chk("idle_done_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.div_done = 1'b0;
        #1;
        chk("idle_done_busy_next", 32'(bus.busy), 32'd0);
        chk("idle_done_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_done_quotient", bus.resp_quotient, 32'd15);

        // Divide by zero on requester 1.
        dvd_tab[1] = 32'd55;
        dvs_tab[1] = 32'd0;
        load_ops();
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        @(negedge clk);
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 1'b1;
        #1;
        chk("dz_req_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("dz_div_start", 32'(bus.div_start), 32'd0);
        chk("dz_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("dz_resp_id", 32'(bus.resp_id), 32'd1);
        chk("dz_quotient", bus.resp_quotient, 32'hFFFF_FFFF);
        chk("dz_remainder", bus.resp_remainder, 32'd55);
        chk("dz_flag", 32'(bus.resp_div_zero), 32'd1);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        chk("dz_after_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("dz_after_busy", 32'(bus.busy), 32'd0);
`else
        run_op(4'b0010, 2, 2'd1, 32'hFFFF_FFFF, 32'd55, 0, 1'b0);
`endif
        dvd_tab[1] = 32'd77;
        dvs_tab[1] = 32'd5;
        load_ops();

        // Reset in WAIT (pointer is 2 here), then a late div_done.
        @(negedge clk);
        bus.req_valid  = 4'b0100;
        bus.resp_ready = 1'b1;
        #1;
        chk("mw_req_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        chk("mw_busy", 32'(bus.busy), 32'd1);
        chk("mw_div_dividend", bus.div_dividend, 32'd100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("rst_midwait");
        rst = 1'b1;
        bus.div_done      = 1'b1;
        bus.div_quotient  = 32'hCAFE_F00D;
        bus.div_remainder = 32'h0000_0BAD;
        @(negedge clk);
        bus.div_done = 1'b0;
        #1;
        chk("late_done_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("late_done_busy", 32'(bus.busy), 32'd0);
        chk("late_done_quotient", bus.resp_quotient, 32'd0);
        // Pointer back at 0: requesters 1 and 3 -> 1 wins.
        run_op(4'b1010, 2, 2'd1, 32'd15, 32'd2, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
